// File: rtl/alu_ctrl_pkg.sv
// ALUControl encodings shared with the ALU decoder, plus the execute FSM state type.
// No logic; constants and a classification helper only.
// Not applicable (package).
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_AUIPC = 4'b1000;
  localparam logic [3:0] ALU_LUI   = 4'b1001;
  localparam logic [3:0] ALU_SRL   = 4'b1010;
  localparam logic [3:0] ALU_SRA   = 4'b1011;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Shifts are the only ops that may run iteratively.
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_seq.sv
// Iterative shifter: moves the accumulator one bit per cycle until the count runs out.
// Latency: shamt cycles from start to done (done is asserted on the final step).
// No backpressure of its own; the parent holds off new work while it runs.
module alu_shift_seq
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] src,
  output logic             done,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc_next;

  // One-bit step of the latched op; SRA replicates the sign bit.
  always_comb begin
    acc_next = acc;
    case (op_q)
      ALU_SLL: acc_next = {acc[WIDTH-2:0], 1'b0};
      ALU_SRL: acc_next = {1'b0, acc[WIDTH-1:1]};
      ALU_SRA: acc_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
      default: acc_next = acc;
    endcase
  end

  // Load on start, then step and count down while work remains.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc  <= '0;
      cnt  <= '0;
      op_q <= ALU_ADD;
    end else if (start) begin
      acc  <= src;
      cnt  <= shamt;
      op_q <= op;
    end else if (cnt != '0) begin
      acc <= acc_next;
      cnt <= cnt - {{(SHW-1){1'b0}}, 1'b1};
    end
  end

  // The last step's shifted value is the result the parent captures.
  assign done  = (cnt == {{(SHW-1){1'b0}}, 1'b1});
  assign value = acc_next;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready on both sides and an iterative shifter for SLL/SRL/SRA.
// Latency: 1 cycle for single-cycle ops and zero-amount shifts; shamt cycles for other shifts.
// Single output slot held stable under out_ready=0; in_ready drops while shifting or when the slot is blocked.
module alu_exec_unit
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  state_t           state;
  logic             accept;
  logic [SHW-1:0]   shamt;
  logic             shift_start;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic             sh_done;
  logic [WIDTH-1:0] sh_value;

  assign shamt       = src_b[SHW-1:0];
  assign in_ready    = (state == IDLE) && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign shift_start = accept && is_shift_op(alu_control) && (shamt != '0);

  // Single-cycle op mux; a zero-amount shift passes src_a straight through.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (alu_control)
      ALU_ADD:   alu_res = src_a + src_b;
      ALU_SUB:   alu_res = src_a - src_b;
      ALU_AND:   alu_res = src_a & src_b;
      ALU_OR:    alu_res = src_a | src_b;
      ALU_XOR:   alu_res = src_a ^ src_b;
      ALU_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:   alu_res = src_a;
      ALU_AUIPC: alu_res = src_a + src_b;
      ALU_LUI:   alu_res = src_b;
      default: begin
        alu_res = '0;
        alu_ill = 1'b1;
      end
    endcase
  end

  alu_shift_seq #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shift (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (shift_start),
    .op      (alu_control),
    .shamt   (shamt),
    .src     (src_a),
    .done    (sh_done),
    .value   (sh_value)
  );

  // FSM and output slot: load on accept or shift completion, drop valid once drained.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (shift_start) begin
            out_valid <= 1'b0;
            state     <= SHIFT;
          end else if (accept) begin
            result    <= alu_res;
            zero      <= (alu_res == '0);
            illegal   <= alu_ill;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        SHIFT: begin
          if (sh_done) begin
            result    <= sh_value;
            zero      <= (sh_value == '0);
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
